call_stack: RTL and testbench

CALL_STACK -- requirements
Module: call_stack

---
 rtl/call_stack.sv | 96 +++++++++
 tb/tb_call_stack.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/call_stack.sv
// LIFO return-address stack with a combinational pop path and sticky overflow/underflow flags.
// Optional macro CALL_STACK_GUARD_EN: a push on a full stack is dropped instead of evicting the oldest entry.
module call_stack #(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    resetBar,
   input  logic [7:0]              pc,
   input  logic                    doCall,
   input  logic                    doRet,
   output logic [7:0]              dbus,
   output logic                    dbusEnBar,
   output logic [$clog2(DEPTH):0]  depth,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int AW  = $clog2(DEPTH);
   localparam int SPW = AW + 1;

   logic [7:0]     r_mem [DEPTH];
   logic [SPW-1:0] r_sp;
   logic           r_ovf;
   logic           r_unf;

   logic [7:0]     w_ret_addr;
   logic [SPW-1:0] w_sp_m1;
   logic [AW-1:0]  w_top_idx;
   logic           w_empty;
   logic           w_full;
   logic           w_pop_ok;
   logic           w_replace;
   logic           w_push;
   logic           w_push_ok;
   logic           w_shift;

   assign w_ret_addr = pc + 8'd1;
   assign w_empty    = (r_sp == '0);
   assign w_full     = (r_sp == SPW'(DEPTH));
   assign w_sp_m1    = r_sp - SPW'(1);
   assign w_top_idx  = w_sp_m1[AW-1:0];
   assign w_pop_ok   = doRet & ~w_empty;
   // Call+return on a non-empty stack overwrites the top; on an empty stack it is a plain push.
   assign w_replace  = doCall & w_pop_ok;
   assign w_push     = doCall & ~w_replace;
   assign w_push_ok  = w_push & ~w_full;
`ifdef CALL_STACK_GUARD_EN
   assign w_shift    = 1'b0;
`else
   assign w_shift    = w_push & w_full;
`endif

   always_ff @(posedge clk or negedge resetBar) begin
      if (!resetBar) begin
         r_sp  <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         if (w_push_ok)
            r_sp <= r_sp + SPW'(1);
         else if (w_pop_ok && !doCall)
            r_sp <= w_sp_m1;
         if (w_push && w_full)
            r_ovf <= 1'b1;
         if (doRet && w_empty)
            r_unf <= 1'b1;
      end
   end

   // Entries are not reset; with sp at zero they cannot reach the bus.
   always_ff @(posedge clk) begin
      if (w_replace) begin
         r_mem[w_top_idx] <= w_ret_addr;
      end else if (w_push_ok) begin
         r_mem[r_sp[AW-1:0]] <= w_ret_addr;
      end else if (w_shift) begin
         for (int unsigned i = 0; i < DEPTH - 1; i++)
            r_mem[AW'(i)] <= r_mem[AW'(i + 1)];
         r_mem[AW'(DEPTH - 1)] <= w_ret_addr;
      end
   end

   always_comb begin
      dbus      = '0;
      dbusEnBar = 1'b1;
      if (w_pop_ok) begin
         dbus      = r_mem[w_top_idx];
         dbusEnBar = 1'b0;
      end
   end

   assign depth     = r_sp;
   assign overflow  = r_ovf;
   assign underflow = r_unf;

endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack: directed vector table, reset-override sequence, and random traffic against a queue model.
module tb_call_stack;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       resetBar = 1'b0;
   logic [7:0] pc = '0;
   logic       doCall = 1'b0;
   logic       doRet = 1'b0;
   logic [7:0] dbus;
   logic       dbusEnBar;
   logic [$clog2(DEPTH):0] depth;
   logic       overflow;
   logic       underflow;

   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      bit         call;
      bit         ret;
      logic [7:0] pc;
      bit         en;
      logic [7:0] db;
      int         dep;
      bit         ovf;
      bit         unf;
   } vec_t;

   vec_t       tbl[$];
   logic [7:0] mq[$];
   bit         m_ovf;
   bit         m_unf;

   call_stack #(.DEPTH(DEPTH)) dut (
      .clk(clk), .resetBar(resetBar), .pc(pc), .doCall(doCall), .doRet(doRet),
      .dbus(dbus), .dbusEnBar(dbusEnBar), .depth(depth),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic addv(input bit c, input bit r, input logic [7:0] p, input bit en,
                       input logic [7:0] db, input int dep, input bit ovf, input bit unf);
      vec_t v;
      v.call = c; v.ret = r; v.pc = p; v.en = en; v.db = db;
      v.dep = dep; v.ovf = ovf; v.unf = unf;
      tbl.push_back(v);
   endtask

   // One clock cycle: drive after the falling edge, check bus before the rising edge, state after it.
   task automatic apply(input string nm, input bit c, input bit r, input logic [7:0] p,
                        input bit en, input logic [7:0] db, input int dep,
                        input bit ovf, input bit unf);
      @(negedge clk);
      doCall = c; doRet = r; pc = p;
      #1;
      chk({nm, ".enbar"}, int'(dbusEnBar), int'(en));
      chk({nm, ".dbus"}, int'(dbus), int'(db));
      @(posedge clk);
      #1;
      chk({nm, ".depth"}, int'(depth), dep);
      chk({nm, ".ovf"}, int'(overflow), int'(ovf));
      chk({nm, ".unf"}, int'(underflow), int'(unf));
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetBar = 1'b0; doCall = 0; doRet = 0;
      @(negedge clk);
      resetBar = 1'b1;
      mq.delete(); m_ovf = 0; m_unf = 0;
   endtask

   // Reference model: stack as a queue, top at the back.
   task automatic model_step(input bit c, input bit r, input logic [7:0] p,
                             output bit en, output logic [7:0] db);
      int n = mq.size();
      logic [7:0] ra = p + 8'd1;
      en = 1; db = 8'h00;
      if (r && n > 0) begin en = 0; db = mq[n-1]; end
      if (r && n == 0) m_unf = 1;
      if (c && r && n > 0) mq[n-1] = ra;
      else if (c) begin
         if (n < DEPTH) mq.push_back(ra);
         else begin
            m_ovf = 1;
`ifndef CALL_STACK_GUARD_EN
            void'(mq.pop_front());
            mq.push_back(ra);
`endif
         end
      end else if (r && n > 0) void'(mq.pop_back());
   endtask

   initial begin
      bit en;
      logic [7:0] db;
      int k;

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset.depth", int'(depth), 0);
      chk("reset.ovf", int'(overflow), 0);
      chk("reset.unf", int'(underflow), 0);
      resetBar = 1'b1;

      addv(0,1,8'h00, 1,8'h00, 0,0,1);
      addv(1,0,8'h10, 1,8'h00, 1,0,1);
      addv(1,0,8'h20, 1,8'h00, 2,0,1);
      addv(0,1,8'h00, 0,8'h21, 1,0,1);
      addv(0,1,8'h00, 0,8'h11, 0,0,1);
      addv(1,0,8'hFF, 1,8'h00, 1,0,1);
      addv(0,1,8'h00, 0,8'h00, 0,0,1);
      addv(1,0,8'h05, 1,8'h00, 1,0,1);
      addv(1,1,8'h30, 0,8'h06, 1,0,1);
      addv(0,1,8'h00, 0,8'h31, 0,0,1);
      addv(1,0,8'h01, 1,8'h00, 1,0,1);
      addv(1,0,8'h02, 1,8'h00, 2,0,1);
      addv(1,0,8'h03, 1,8'h00, 3,0,1);
      addv(1,0,8'h04, 1,8'h00, 4,0,1);
      addv(1,0,8'h05, 1,8'h00, 4,1,1);
`ifdef CALL_STACK_GUARD_EN
      addv(0,1,8'h00, 0,8'h05, 3,1,1);
      addv(0,1,8'h00, 0,8'h04, 2,1,1);
      addv(0,1,8'h00, 0,8'h03, 1,1,1);
      addv(0,1,8'h00, 0,8'h02, 0,1,1);
`else
      addv(0,1,8'h00, 0,8'h06, 3,1,1);
      addv(0,1,8'h00, 0,8'h05, 2,1,1);
      addv(0,1,8'h00, 0,8'h04, 1,1,1);
      addv(0,1,8'h00, 0,8'h03, 0,1,1);
`endif
      addv(1,1,8'h40, 1,8'h00, 1,1,1);
      addv(0,1,8'h00, 0,8'h41, 0,1,1);

      for (int i = 0; i < tbl.size(); i++)
         apply($sformatf("v%0d", i), tbl[i].call, tbl[i].ret, tbl[i].pc,
               tbl[i].en, tbl[i].db, tbl[i].dep, tbl[i].ovf, tbl[i].unf);

      // Mid-cycle reset with a push pending, held across an edge
      do_reset();
      apply("pre0", 1,0,8'h70, 1,8'h00, 1,0,0);
      apply("pre1", 1,0,8'h71, 1,8'h00, 2,0,0);
      apply("pre2", 0,1,8'h00, 0,8'h72, 1,0,0);
      apply("pre3", 1,0,8'h72, 1,8'h00, 2,0,0);
      apply("pre4", 1,0,8'h73, 1,8'h00, 3,0,0);
      @(negedge clk);
      doCall = 1; doRet = 1; pc = 8'h55;
      #2 resetBar = 1'b0;
      #1;
      chk("arst.depth", int'(depth), 0);
      chk("arst.ovf", int'(overflow), 0);
      chk("arst.unf", int'(underflow), 0);
      chk("arst.enbar", int'(dbusEnBar), 1);
      @(posedge clk); #1;
      chk("arst.hold", int'(depth), 0);
      @(negedge clk);
      resetBar = 1'b1; doCall = 0; doRet = 0;
      apply("arst.pop", 0,1,8'h00, 1,8'h00, 0,0,1);

      // Random traffic against the model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         bit c, r;
         logic [7:0] p;
         k = $urandom_range(0, 9);
         c = (k < 5) || (k == 9);
         r = (k >= 5);
         p = 8'($urandom);
         model_step(c, r, p, en, db);
         apply($sformatf("r%0d", i), c, r, p, en, db, mq.size(), m_ovf, m_unf);
         if ($urandom_range(0, 99) == 0) do_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, %0d/%0d", n_pass, n_total);
      $fatal(1);
   end

endmodule
